// File: rtl/sw_debounce_io.sv
// sw_debounce_io: memory-mapped switch input with synchroniser, per-bit debounce and W1C change events.
// Define SWDB_FILTER_EN to build the tick-based debounce filter; undefined gives a 3-cycle pass-through.
module sw_debounce_io #(
    parameter int          WIDTH    = 24,
    parameter int          TICK_DIV = 50000,
    parameter int          STABLE_N = 8,
    parameter logic [31:0] SW_ADDR  = 32'hFFFF_F070,
    parameter logic [31:0] EVT_ADDR = 32'hFFFF_F074
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] device_sw,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [31:0]      wr,
    output logic [31:0]      rd,
    output logic             hit,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] evt
);
    logic [WIDTH-1:0] meta, sync, flip, clr;
    logic             hit_sw, hit_evt;
    logic             unused_wr;

    assign unused_wr = &{1'b0, wr};

    // two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= device_sw;
            sync <= meta;
        end
    end

`ifdef SWDB_FILTER_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_N);

    logic [PW-1:0] pre;
    logic          tick;
    logic [CW-1:0] cnt [WIDTH];

    assign tick = (pre == PW'(TICK_DIV - 1));

    // shared sample prescaler, wraps after TICK_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst_n) pre <= '0;
        else        pre <= tick ? '0 : pre + 1'b1;
    end

    // a bit flips on the STABLE_N-th consecutive differing sample
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++)
            flip[i] = tick && (sync[i] != sw_stable[i]) && (cnt[i] == CW'(STABLE_N - 1));
    end

    // per-bit run counters; any matching sample restarts the run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            sw_stable <= '0;
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= (sync[i] == sw_stable[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
            sw_stable <= sw_stable ^ flip;
        end
    end
`else
    // fast path: every differing synchronised bit flips immediately
    always_comb flip = sync ^ sw_stable;

    // stable state simply follows the synchroniser
    always_ff @(posedge clk) begin
        if (!rst_n) sw_stable <= '0;
        else        sw_stable <= sync;
    end
`endif

    assign hit_sw  = (addr == SW_ADDR);
    assign hit_evt = (addr == EVT_ADDR);
    assign hit     = hit_sw || hit_evt;
    assign clr     = (we && hit_evt) ? wr[WIDTH-1:0] : '0;

    // sticky change flags; a new flip beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) evt <= '0;
        else        evt <= (evt & ~clr) | flip;
    end

    // side-effect-free read mux, zero-extended above WIDTH
    always_comb rd = hit_sw ? 32'(sw_stable) : hit_evt ? 32'(evt) : 32'h0;
endmodule

// File: tb/tb_sw_debounce_io.sv
// tb_sw_debounce_io: directed bench with a sample-history reference model, checked every cycle.
module tb_sw_debounce_io;
    localparam int          W    = 24;
    localparam int          TD   = 4;
    localparam int          SN   = 3;
    localparam logic [31:0] SWA  = 32'hFFFF_F070;
    localparam logic [31:0] EVA  = 32'hFFFF_F074;

    logic          clk = 0, rst_n = 0, we = 0;
    logic [W-1:0]  device_sw = '1;
    logic [31:0]   addr = 32'h0, wr = 32'h0, rd;
    logic          hit;
    logic [W-1:0]  sw_stable, evt;

    int n_chk = 0, n_fail = 0;

    sw_debounce_io #(.WIDTH(W), .TICK_DIV(TD), .STABLE_N(SN), .SW_ADDR(SWA), .EVT_ADDR(EVA)) dut (
        .clk(clk), .rst_n(rst_n), .device_sw(device_sw), .addr(addr), .we(we), .wr(wr),
        .rd(rd), .hit(hit), .sw_stable(sw_stable), .evt(evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: remembers raw input history and tick sample runs since the last flip
    logic [W-1:0] hist [$];
    logic [W-1:0] m_stable = '0, m_evt = '0;
    int           k = 0;
    int           run [W];
    bit           started = 0;

    always @(posedge clk) begin
        logic [W-1:0] s, f, c;
        started = 1;
        if (!rst_n) begin
            hist = {};
            k = 0;
            m_stable = '0;
            m_evt = '0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            s = (hist.size() >= 2) ? hist[1] : '0;
            f = '0;
`ifdef SWDB_FILTER_EN
            if (k % TD == TD - 1)
                for (int i = 0; i < W; i++) begin
                    if (s[i] == m_stable[i]) run[i] = 0;
                    else begin
                        run[i]++;
                        if (run[i] == SN) begin
                            f[i] = 1'b1;
                            run[i] = 0;
                        end
                    end
                end
`else
            f = s ^ m_stable;
`endif
            c = (we && addr == EVA) ? wr[W-1:0] : '0;
            m_evt = (m_evt & ~c) | f;
            m_stable = m_stable ^ f;
            hist.push_front(device_sw);
            if (hist.size() > 3) void'(hist.pop_back());
            k++;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("model sw_stable", 32'(sw_stable), 32'(m_stable));
            check("model evt", 32'(evt), 32'(m_evt));
            check("model hit", 32'(hit), 32'(addr == SWA || addr == EVA));
            check("model rd", rd, addr == SWA ? 32'(m_stable) : addr == EVA ? 32'(m_evt) : 32'h0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
`ifdef SWDB_FILTER_EN
        bit filt = 1;
`else
        bit filt = 0;
`endif
        // 1: reset with all switches high
        cyc(3);
        addr = SWA;
        #1 check("reset rd sw", rd, 32'h0);
        check("reset sw_stable", 32'(sw_stable), 32'h0);
        addr = EVA;
        #1 check("reset rd evt", rd, 32'h0);
        check("reset evt", 32'(evt), 32'h0);
        device_sw = '0;
        rst_n = 1;
        cyc(20);

        // 2: clean rising edge on bit 0
        device_sw[0] = 1'b1;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (sw_stable[0]) break;
        end
        #1;
        if (filt) check("latency bit0 in 10..14", 32'(n >= 10 && n <= 14), 32'h1);
        else      check("latency bit0 fast", 32'(n), 32'd3);
        cyc(1);
        addr = SWA;
        #1 check("rd sw after edge", rd, 32'h1);
        check("hit sw", 32'(hit), 32'h1);
        check("evt after edge", 32'(evt), 32'h1);
        #1;

        // 3: short pulse on bit 5
        device_sw[5] = 1'b1;
        cyc(2 * TD);
        device_sw[5] = 1'b0;
        cyc(40);
        check("glitch sw_stable5", 32'(sw_stable[5]), 32'h0);
        check("glitch evt", 32'(evt), filt ? 32'h1 : 32'h21);

        // 4a: write-1-to-clear bit 0
        addr = EVA; we = 1; wr = 32'h1;
        cyc(1);
        we = 0;
        #1 check("w1c evt", 32'(evt), filt ? 32'h0 : 32'h20);
        #1;
        // 4b: keep clearing while bit 0 falls; the flip must survive its store cycle
        device_sw[0] = 1'b0;
        we = 1;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (!sw_stable[0]) break;
        end
        check("fall seen in bound", 32'(n <= 40), 32'h1);
        check("set beats clear", 32'(evt[0]), 32'h1);
        #1 we = 0;
        cyc(1);

        // 5: unmapped store and store to the read-only register
        addr = 32'hFFFF_F078; we = 1; wr = 32'hFFFF_FFFF;
        #1 check("unmapped rd", rd, 32'h0);
        check("unmapped hit", 32'(hit), 32'h0);
        cyc(1);
        addr = SWA;
        cyc(1);
        we = 0;
        #1 check("after stores sw_stable", 32'(sw_stable), 32'h0);
        check("after stores evt", 32'(evt), filt ? 32'h1 : 32'h21);
        #1;

        // 6: partial progress on bit 3 then a reset discards it
        device_sw[3] = 1'b1;
        cyc(2 + 2 * TD);
        rst_n = 0;
        cyc(1);
        rst_n = 1;
        #1 check("mid reset sw_stable", 32'(sw_stable), 32'h0);
        check("mid reset evt", 32'(evt), 32'h0);
        #1;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (sw_stable[3]) break;
        end
        check("latency after reset", 32'(n), filt ? 32'd12 : 32'd3);
        #1;
        cyc(3);
        check("final evt", 32'(evt), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
